// File: rtl/aes_v2_pkg.sv
// Shared types and constants for the AES v2 round sequencer: state enum,
// column/step counts and the word-index helpers used by the operand selector.
package aes_v2_pkg;

  localparam int AES_NCOL       = 4;
  localparam int AES_WORD_W     = 32;
  localparam int AES_STEPS_FULL = 8;
  localparam int AES_STEPS_LAST = 4;
  localparam int AES_STEP_W     = 3;

  // Column offsets; 2-bit arithmetic wraps modulo AES_NCOL for free.
  localparam logic [1:0] COL_NEXT = 2'd1;
  localparam logic [1:0] COL_HALF = 2'd2;
  localparam logic [1:0] COL_TOP  = 2'(AES_NCOL - 1);

  localparam logic [AES_STEP_W-1:0] STEP_END_FULL = AES_STEP_W'(AES_STEPS_FULL - 1);
  localparam logic [AES_STEP_W-1:0] STEP_END_LAST = AES_STEP_W'(AES_STEPS_LAST - 1);

  typedef logic [AES_WORD_W-1:0] word_t;
  typedef word_t [AES_NCOL-1:0]  words_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2,
    FIN   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/aes_v2_round_seq_if.sv
// Request/response bus between the round sequencer (master) and the shared
// SubBytes/MixColumns unit (slave).
interface aes_v2_round_seq_if;
  import aes_v2_pkg::*;

  // Handshake: the master raises aes_valid with sub/enc/rot/rs1/rs2 stable and
  // keeps them unchanged until the slave answers with aes_ready=1 and aes_rd
  // valid in the same cycle; that cycle completes the transfer. aes_ready is
  // meaningless while aes_valid is low.
  logic  aes_valid;
  logic  aes_sub;
  logic  aes_enc;
  logic  aes_rot;
  word_t aes_rs1;
  word_t aes_rs2;
  logic  aes_ready;
  word_t aes_rd;

  modport master (
    output aes_valid, aes_sub, aes_enc, aes_rot, aes_rs1, aes_rs2,
    input  aes_ready, aes_rd
  );

  modport slave (
    input  aes_valid, aes_sub, aes_enc, aes_rot, aes_rs1, aes_rs2,
    output aes_ready, aes_rd
  );

endinterface

// File: rtl/aes_v2_round_seq_opsel.sv
// Operand selector: maps a step number onto the operands and controls of that
// step. Steps 0-3 are sub steps over S, steps 4-7 are mix steps over T.
module aes_v2_round_seq_opsel
  import aes_v2_pkg::*;
(
  input  logic [AES_STEP_W-1:0] step,
  input  words_t                s,
  input  words_t                t,
  output word_t                 rs1,
  output word_t                 rs2,
  output logic                  sub,
  output logic                  rot
);

  logic [1:0] col;

  always_comb begin
    col = step[1:0];
    sub = ~step[2];
    rs1 = '0;
    rs2 = '0;
    rot = 1'b0;
    if (sub) begin
      rs1 = s[col];
      rs2 = s[col + COL_NEXT];
      rot = step[0];
    end else begin
      rs1 = t[col];
      rs2 = t[col + COL_HALF];
    end
  end

endmodule

// File: rtl/aes_v2_round_seq.sv
// AES v2 round sequencer: issues the sub/mix steps of one round to the shared
// unit and returns the new state. AES_V2_ROUND_SEQ_KEYXOR_EN enables AddRoundKey.
module aes_v2_round_seq
  import aes_v2_pkg::*;
(
  input  logic                g_clk,
  input  logic                g_reset,
  input  logic                start,
  input  logic                enc,
  input  logic                last,
  input  logic [127:0]        state_in,
  input  logic [127:0]        rkey,
  output logic                busy,
  output logic                done,
  output logic [127:0]        state_out,
  aes_v2_round_seq_if.master  aes,
  output seq_state_e          dbg_state
);

  seq_state_e            state_q, state_d;
  logic [AES_STEP_W-1:0] step_q;
  logic                  enc_q;
  logic                  last_q;
  words_t                s_q, t_q, u_q;
  words_t                work_fin;
  words_t                result;
  logic [127:0]          state_out_q;
  logic                  accept, capture, final_step;
  word_t                 op_rs1, op_rs2;
  logic                  op_sub, op_rot;

  assign accept     = (state_q == IDLE) && start;
  assign capture    = (state_q == ISSUE) && aes.aes_ready;
  assign final_step = last_q ? (step_q == STEP_END_LAST) : (step_q == STEP_END_FULL);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ISSUE;
      ISSUE:   if (aes.aes_ready) state_d = final_step ? FIN : GAP;
      GAP:     state_d = ISSUE;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The last step of either round kind lands in column 3, so the final word
  // comes straight from the unit while the other three are already stored.
  always_comb begin
    work_fin          = last_q ? t_q : u_q;
    work_fin[COL_TOP] = aes.aes_rd;
  end

`ifdef AES_V2_ROUND_SEQ_KEYXOR_EN
  words_t key_q;

  assign result = work_fin ^ key_q;

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset)     key_q <= '0;
    else if (accept) key_q <= rkey;
  end
`else
  logic unused_rkey;

  assign unused_rkey = ^rkey;
  assign result      = work_fin;
`endif

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q     <= IDLE;
      step_q      <= '0;
      enc_q       <= 1'b0;
      last_q      <= 1'b0;
      s_q         <= '0;
      t_q         <= '0;
      u_q         <= '0;
      state_out_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        enc_q  <= enc;
        last_q <= last;
        s_q    <= state_in;
        step_q <= '0;
      end
      if (capture) begin
        if (!step_q[2]) t_q[step_q[1:0]] <= aes.aes_rd;
        else            u_q[step_q[1:0]] <= aes.aes_rd;
        if (final_step) state_out_q <= result;
        else            step_q      <= step_q + 1'b1;
      end
    end
  end

  aes_v2_round_seq_opsel u_opsel (
    .step (step_q),
    .s    (s_q),
    .t    (t_q),
    .rs1  (op_rs1),
    .rs2  (op_rs2),
    .sub  (op_sub),
    .rot  (op_rot)
  );

  // Operands only depend on registered step/work state, so they hold steady
  // for the whole ISSUE period; outside ISSUE the bus is driven to zero.
  assign aes.aes_valid = (state_q == ISSUE);
  assign aes.aes_sub   = (state_q == ISSUE) && op_sub;
  assign aes.aes_rot   = (state_q == ISSUE) && op_rot;
  assign aes.aes_rs1   = (state_q == ISSUE) ? op_rs1 : '0;
  assign aes.aes_rs2   = (state_q == ISSUE) ? op_rs2 : '0;
  assign aes.aes_enc   = enc_q;

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign state_out = state_out_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_aes_v2_round_seq.sv
// Directed bench for aes_v2_round_seq with an XOR stub standing in for the
// shared unit (rd = rs1 ^ rs2, ready after a programmable number of wait cycles).
module tb_aes_v2_round_seq;
  import aes_v2_pkg::*;

  logic         g_clk = 1'b0;
  logic         g_reset;
  logic         start, enc, last;
  logic [127:0] state_in, rkey;
  logic         busy, done;
  logic [127:0] state_out;
  seq_state_e   dbg_state;

  aes_v2_round_seq_if bus ();

  aes_v2_round_seq dut (
    .g_clk     (g_clk),
    .g_reset   (g_reset),
    .start     (start),
    .enc       (enc),
    .last      (last),
    .state_in  (state_in),
    .rkey      (rkey),
    .busy      (busy),
    .done      (done),
    .state_out (state_out),
    .aes       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 g_clk = ~g_clk;

  // stub unit
  int lat  = 0;
  int wcnt = 0;

  always_comb begin
    bus.aes_ready = bus.aes_valid && (wcnt == lat);
    bus.aes_rd    = bus.aes_rs1 ^ bus.aes_rs2;
  end

  always @(posedge g_clk) begin
    if (bus.aes_valid && !bus.aes_ready) wcnt <= wcnt + 1;
    else                                 wcnt <= 0;
  end

  // scoreboard
  localparam logic [127:0] SI      = {32'd8, 32'd4, 32'd2, 32'd1};
  localparam logic [127:0] KEY_F   = {128{1'b1}};
  localparam logic [127:0] EXP_LAST = 128'h00000009_0000000C_00000006_00000003;
  localparam logic [127:0] EXP_FULL_K0 = {4{32'h0000000F}};
`ifdef AES_V2_ROUND_SEQ_KEYXOR_EN
  localparam logic [127:0] EXP_FULL_KF = {4{32'hFFFFFFF0}};
`else
  localparam logic [127:0] EXP_FULL_KF = {4{32'h0000000F}};
`endif

  logic [127:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver: one round, optional extra start pulses s1/s2 (0 = none)
  task automatic run_round(input int l, input logic lst, input logic [127:0] key,
                           input logic [127:0] expv, input int exp_done,
                           input int s1, input int s2);
    int           done_cnt;
    int           done_at;
    logic         prev_valid;
    logic [31:0]  prev_rs1, prev_rs2;
    lat = l;
    exp_q.push_back(expv);
    @(negedge g_clk);
    start = 1'b1; enc = 1'b1; last = lst; state_in = SI; rkey = key;
    done_cnt = 0; done_at = -1; prev_valid = 1'b0; prev_rs1 = '0; prev_rs2 = '0;
    for (int c = 1; c <= exp_done + 4; c++) begin
      @(negedge g_clk);
      start = (c == s1) || (c == s2);
      if (c == 1) begin
        check("busy_c1", 128'(busy), 128'd1);
        check("rs1_step0", 128'(bus.aes_rs1), 128'd1);
        check("rs2_step0", 128'(bus.aes_rs2), 128'd2);
        check("sub_step0", 128'(bus.aes_sub), 128'd1);
        check("enc_latched", 128'(bus.aes_enc), 128'd1);
      end
      if (c == 3) check("rot_step1", 128'(bus.aes_rot), 128'(l == 0));
      if (l == 0 && c < exp_done && (c % 2) == 0)
        check("valid_gap", 128'(bus.aes_valid), 128'd0);
      if (bus.aes_valid && prev_valid) begin
        check("rs1_stable", 128'(bus.aes_rs1), 128'(prev_rs1));
        check("rs2_stable", 128'(bus.aes_rs2), 128'(prev_rs2));
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = c;
          check("state_out", state_out, exp_q.pop_front());
        end
      end
      prev_valid = bus.aes_valid;
      prev_rs1   = bus.aes_rs1;
      prev_rs2   = bus.aes_rs2;
    end
    start = 1'b0;
    check("done_cycle", 128'(done_at), 128'(exp_done));
    check("done_count", 128'(done_cnt), 128'd1);
    check("busy_after", 128'(busy), 128'd0);
    check("state_out_hold", state_out, expv);
    if (done_at < 0) void'(exp_q.pop_front());
  endtask

  initial begin
    g_reset = 1'b1; start = 1'b0; enc = 1'b0; last = 1'b0;
    state_in = '0; rkey = '0;
    repeat (3) @(negedge g_clk);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    check("rst_state_out", state_out, 128'd0);
    check("rst_valid", 128'(bus.aes_valid), 128'd0);
    check("rst_sub", 128'(bus.aes_sub), 128'd0);
    check("rst_rs1", 128'(bus.aes_rs1), 128'd0);
    check("rst_rs2", 128'(bus.aes_rs2), 128'd0);
    check("rst_enc", 128'(bus.aes_enc), 128'd0);
    check("rst_dbg_state", 128'(dbg_state), 128'(IDLE));
    g_reset = 1'b0;
    @(negedge g_clk);

    run_round(0, 1'b1, 128'd0, EXP_LAST, 8, 0, 0);
    run_round(0, 1'b0, KEY_F, EXP_FULL_KF, 16, 0, 0);
    run_round(2, 1'b0, KEY_F, EXP_FULL_KF, 32, 0, 0);
    run_round(0, 1'b0, KEY_F, EXP_FULL_KF, 16, 3, 16);

    // reset in cycle 5 of a full round (step 2 in ISSUE)
    lat = 0;
    @(negedge g_clk);
    start = 1'b1; last = 1'b0; state_in = SI; rkey = KEY_F;
    for (int c = 1; c <= 5; c++) begin
      @(negedge g_clk);
      start = 1'b0;
    end
    check("pre_rst_valid", 128'(bus.aes_valid), 128'd1);
    g_reset = 1'b1;
    #1;
    check("mid_rst_valid", 128'(bus.aes_valid), 128'd0);
    check("mid_rst_busy", 128'(busy), 128'd0);
    check("mid_rst_done", 128'(done), 128'd0);
    check("mid_rst_state_out", state_out, 128'd0);
    check("mid_rst_dbg_state", 128'(dbg_state), 128'(IDLE));
    @(negedge g_clk);
    g_reset = 1'b0;

    run_round(0, 1'b0, 128'd0, EXP_FULL_K0, 16, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
